// File: rtl/pipe_pkg.sv
// pipe_pkg: shared RV32I pipeline encodings and the ID/EX control bundle
package pipe_pkg;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] aluop;
    logic       regwrite;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  // rs2 is read by register-register ops, stores (data) and branches (compare)
  function automatic logic uses_rs2(input ctrl_t c);
    return ~c.alusrc | c.memwrite | c.branch;
  endfunction
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX is about to write
module load_use_detect #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_valid,
  input  logic               ex_memread,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               id_valid,
  input  logic               use_rs2,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  output logic               hazard
);
  assign hazard = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (use_rs2 & (ex_rd == id_rs2)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register that turns flushes and load-use hazards into bubbles
// Define ID_EX_PERF_EN to add saturating bubble/flush performance counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef ID_EX_PERF_EN
  output logic [31:0]        perf_bubble_cnt_o,
  output logic [31:0]        perf_flush_cnt_o,
`endif
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic               id_branch_i,
  input  logic               id_memread_i,
  input  logic               id_memwrite_i,
  input  logic               id_memtoreg_i,
  input  logic               id_alusrc_i,
  input  logic               id_regwrite_i,
  input  logic [1:0]         id_aluop_i,
  input  logic [XLEN-1:0]    id_rs1_data_i,
  input  logic [XLEN-1:0]    id_rs2_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [9:0]         id_funct_i,
  input  logic [RADDR_W-1:0] id_rs1_addr_i,
  input  logic [RADDR_W-1:0] id_rs2_addr_i,
  input  logic [RADDR_W-1:0] id_rd_addr_i,
  output logic               ex_valid_o,
  output logic               ex_branch_o,
  output logic               ex_memread_o,
  output logic               ex_memwrite_o,
  output logic               ex_memtoreg_o,
  output logic               ex_alusrc_o,
  output logic               ex_regwrite_o,
  output logic [1:0]         ex_aluop_o,
  output logic [XLEN-1:0]    ex_rs1_data_o,
  output logic [XLEN-1:0]    ex_rs2_data_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [9:0]         ex_funct_o,
  output logic [RADDR_W-1:0] ex_rs1_addr_o,
  output logic [RADDR_W-1:0] ex_rs2_addr_o,
  output logic [RADDR_W-1:0] ex_rd_addr_o,
  output logic               hazard_stall_o
);
  ctrl_t id_ctrl, ex_ctrl;
  logic  load_use, bubble;
  assign id_ctrl = '{branch: id_branch_i, memread: id_memread_i, memwrite: id_memwrite_i,
                     memtoreg: id_memtoreg_i, alusrc: id_alusrc_i, aluop: id_aluop_i,
                     regwrite: id_regwrite_i};
  load_use_detect #(.RADDR_W(RADDR_W)) u_lud (
    .ex_valid  (ex_valid_o),
    .ex_memread(ex_ctrl.memread),
    .ex_rd     (ex_rd_addr_o),
    .id_valid  (id_valid_i),
    .use_rs2   (uses_rs2(id_ctrl)),
    .id_rs1    (id_rs1_addr_i),
    .id_rs2    (id_rs2_addr_i),
    .hazard    (load_use)
  );
  // a flushed instruction never issues, so it cannot stall on a load
  assign hazard_stall_o = load_use & ~flush_i;
  assign bubble         = flush_i | hazard_stall_o;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_ctrl       <= CTRL_NOP;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_pc_o       <= '0;
      ex_funct_o    <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
    end else if (!stall_i) begin
      ex_valid_o    <= id_valid_i & ~bubble;
      ex_ctrl       <= (bubble | ~id_valid_i) ? CTRL_NOP : id_ctrl;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_pc_o       <= id_pc_i;
      ex_funct_o    <= id_funct_i;
      ex_rs1_addr_o <= id_rs1_addr_i;
      ex_rs2_addr_o <= id_rs2_addr_i;
      ex_rd_addr_o  <= id_rd_addr_i;
    end
  end
  assign ex_branch_o   = ex_ctrl.branch;
  assign ex_memread_o  = ex_ctrl.memread;
  assign ex_memwrite_o = ex_ctrl.memwrite;
  assign ex_memtoreg_o = ex_ctrl.memtoreg;
  assign ex_alusrc_o   = ex_ctrl.alusrc;
  assign ex_aluop_o    = ex_ctrl.aluop;
  assign ex_regwrite_o = ex_ctrl.regwrite;
`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_bubble_cnt_o <= '0;
      perf_flush_cnt_o  <= '0;
    end else if (!stall_i) begin
      perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'(hazard_stall_o & ~&perf_bubble_cnt_o);
      perf_flush_cnt_o  <= perf_flush_cnt_o + 32'(flush_i & ~&perf_flush_cnt_o);
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven bench for id_ex_stage with a scoreboard of expected EX-side values
module tb_id_ex_stage;
  localparam logic [7:0] R_ADD = 8'h05;
  localparam logic [7:0] LW    = 8'h59;
  localparam logic [7:0] SW    = 8'h28;
  localparam logic [7:0] ADDI  = 8'h0F;
  localparam logic [7:0] BEQ   = 8'h82;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
  logic        id_branch_i = 1'b0, id_memread_i = 1'b0, id_memwrite_i = 1'b0;
  logic        id_memtoreg_i = 1'b0, id_alusrc_i = 1'b0, id_regwrite_i = 1'b0;
  logic [1:0]  id_aluop_i = '0;
  logic [31:0] id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0, id_pc_i = '0;
  logic [9:0]  id_funct_i = '0;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
  logic        ex_valid_o, ex_branch_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
  logic        ex_alusrc_o, ex_regwrite_o, hazard_stall_o;
  logic [1:0]  ex_aluop_o;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
  logic [9:0]  ex_funct_o;
  logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt_o, perf_flush_cnt_o;
`endif
  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i),
`ifdef ID_EX_PERF_EN
    .perf_bubble_cnt_o(perf_bubble_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_branch_i(id_branch_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
    .id_memtoreg_i(id_memtoreg_i), .id_alusrc_i(id_alusrc_i), .id_regwrite_i(id_regwrite_i),
    .id_aluop_i(id_aluop_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i), .id_funct_i(id_funct_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .ex_valid_o(ex_valid_o), .ex_branch_o(ex_branch_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_aluop_o(ex_aluop_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
    .ex_funct_o(ex_funct_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .hazard_stall_o(hazard_stall_o)
  );
  typedef struct packed {
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [9:0]  funct;
    logic [4:0]  rs1a, rs2a;
  } dat_t;
  typedef struct {
    logic       rst_n, stall, flush, valid;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       chk_hz, exp_hz, exp_valid;
    logic [7:0] exp_ctrl;
    logic [4:0] exp_rd;
  } vec_t;
  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    dat_t        d;
    logic [31:0] bub, fl;
  } exp_t;
  vec_t v[$];
  exp_t sb[$];
  int pass_cnt = 0, total = 0;
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] want);
    total++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, want);
  endtask
  task automatic row(input logic rst_n, stall, flush, valid, input logic [7:0] ctrl,
                     input logic [4:0] rs1, rs2, rd, input logic chk_hz, exp_hz, exp_valid,
                     input logic [7:0] exp_ctrl, input logic [4:0] exp_rd);
    v.push_back('{rst_n, stall, flush, valid, ctrl, rs1, rs2, rd, chk_hz, exp_hz, exp_valid,
                  exp_ctrl, exp_rd});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    dat_t        d, last;
    exp_t        e;
    logic [31:0] eb, ef;
    last = '0; eb = '0; ef = '0;
    //  rst stl fl  val ctrl   rs1 rs2 rd  chk hz  ev  ectrl  erd
    row(0, 0, 0, 1, LW,    1,  2,  6,  0,  0,  0, 8'h00, 0);
    row(0, 0, 0, 1, LW,    6,  6,  6,  1,  0,  0, 8'h00, 0);
    row(1, 0, 0, 1, R_ADD, 3,  4,  5,  1,  0,  1, R_ADD, 5);
    row(1, 0, 0, 1, LW,    1,  0,  6,  1,  0,  1, LW,    6);
    row(1, 0, 0, 1, R_ADD, 6,  2,  7,  1,  1,  0, 8'h00, 7);
    row(1, 0, 0, 1, R_ADD, 6,  2,  7,  1,  0,  1, R_ADD, 7);
    row(1, 0, 0, 1, LW,    1,  0,  0,  1,  0,  1, LW,    0);
    row(1, 0, 0, 1, R_ADD, 0,  2,  7,  1,  0,  1, R_ADD, 7);
    row(1, 0, 0, 1, LW,    1,  0,  6,  1,  0,  1, LW,    6);
    row(1, 0, 1, 1, SW,    1,  6,  0,  1,  0,  0, 8'h00, 0);
    row(1, 0, 0, 1, LW,    1,  0,  6,  1,  0,  1, LW,    6);
    row(1, 0, 0, 1, ADDI,  2,  6,  8,  1,  0,  1, ADDI,  8);
    row(1, 0, 0, 1, LW,    1,  0,  9,  1,  0,  1, LW,    9);
    row(1, 0, 0, 1, BEQ,   1,  9,  0,  1,  1,  0, 8'h00, 0);
    row(1, 0, 0, 1, BEQ,   1,  9,  0,  1,  0,  1, BEQ,   0);
    row(1, 0, 0, 0, LW,    1,  0,  10, 1,  0,  0, 8'h00, 10);
    row(1, 0, 0, 1, LW,    1,  0,  11, 1,  0,  1, LW,    11);
    row(1, 0, 0, 0, R_ADD, 11, 2,  12, 1,  0,  0, 8'h00, 12);
    row(1, 0, 0, 1, LW,    1,  0,  13, 1,  0,  1, LW,    13);
    row(1, 1, 0, 1, R_ADD, 13, 2,  14, 1,  1,  1, LW,    13);
    row(1, 1, 0, 1, SW,    2,  3,  0,  1,  0,  1, LW,    13);
    row(1, 1, 0, 1, R_ADD, 2,  13, 15, 1,  1,  1, LW,    13);
    row(1, 0, 0, 1, ADDI,  4,  5,  16, 1,  0,  1, ADDI,  16);
    row(1, 0, 1, 1, SW,    1,  2,  0,  1,  0,  0, 8'h00, 0);
    row(0, 1, 0, 1, LW,    1,  2,  3,  1,  0,  0, 8'h00, 0);
    foreach (v[i]) begin
      @(negedge clk);
      d.rs1d = $urandom; d.rs2d = $urandom; d.imm = $urandom; d.pc = $urandom;
      d.funct = 10'($urandom); d.rs1a = v[i].rs1; d.rs2a = v[i].rs2;
      rst_i = v[i].rst_n; stall_i = v[i].stall; flush_i = v[i].flush; id_valid_i = v[i].valid;
      {id_branch_i, id_memread_i, id_memwrite_i, id_memtoreg_i, id_alusrc_i, id_aluop_i,
       id_regwrite_i} = v[i].ctrl;
      id_rs1_data_i = d.rs1d; id_rs2_data_i = d.rs2d; id_imm_i = d.imm; id_pc_i = d.pc;
      id_funct_i = d.funct; id_rs1_addr_i = v[i].rs1; id_rs2_addr_i = v[i].rs2;
      id_rd_addr_i = v[i].rd;
      #1;
      if (v[i].chk_hz) chk($sformatf("hazard[%0d]", i), 160'(hazard_stall_o), 160'(v[i].exp_hz));
      if (!v[i].rst_n) begin
        last = '0; eb = '0; ef = '0;
      end else if (!v[i].stall) begin
        last = d;
        eb = eb + 32'(v[i].exp_hz && eb != '1);
        ef = ef + 32'(v[i].flush && ef != '1);
      end
      sb.push_back('{v[i].exp_valid, v[i].exp_ctrl, v[i].exp_rd, last, eb, ef});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("valid[%0d]", i), 160'(ex_valid_o), 160'(e.valid));
      chk($sformatf("ctrl[%0d]", i), 160'({ex_branch_o, ex_memread_o, ex_memwrite_o,
          ex_memtoreg_o, ex_alusrc_o, ex_aluop_o, ex_regwrite_o}), 160'(e.ctrl));
      chk($sformatf("rd[%0d]", i), 160'(ex_rd_addr_o), 160'(e.rd));
      chk($sformatf("data[%0d]", i), 160'({ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o,
          ex_funct_o, ex_rs1_addr_o, ex_rs2_addr_o}), 160'(e.d));
`ifdef ID_EX_PERF_EN
      chk($sformatf("perf_bubble[%0d]", i), 160'(perf_bubble_cnt_o), 160'(e.bub));
      chk($sformatf("perf_flush[%0d]", i), 160'(perf_flush_cnt_o), 160'(e.fl));
`endif
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
